fb_write_arbiter: RTL and testbench

- Shares the single framebuffer write port (gpu_clk domain) between NUM_REQ write requesters, e.g. the display processor and a fill/blit engine.
- Uses round-robin arbitration with burst locking.
- Caps each burst at MAX_BURST beats and releases an idle lock after IDLE_TIMEOUT cycles, so no requester can starve the others.
- Drives fb_wr_addr, fb_wr_data and fb_wr_en (byte-enable) through one register stage.

---
 rtl/fb_write_arbiter.sv | 123 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing one framebuffer write port between NUM_REQ burst writers.
// A grant locks until req_last, a MAX_BURST cutoff, or IDLE_TIMEOUT idle cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no lock held; pick next valid requester after last_grant
// ST_LOCKED | grant_idx owns the port; its beats pass through one register

module fb_write_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_BITS    = 17,
  parameter int DATA_BITS    = 32,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8,
  localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int STRB_BITS   = DATA_BITS / 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  input  logic [NUM_REQ*STRB_BITS-1:0]   req_strb,
  output logic [ADDR_BITS-1:0]           fb_wr_addr,
  output logic [DATA_BITS-1:0]           fb_wr_data,
  output logic [STRB_BITS-1:0]           fb_wr_en,
  output logic                           grant_valid,
  output logic [IDX_W-1:0]               grant_idx
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state;
  logic [IDX_W-1:0]     last_grant;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [IDLE_W-1:0]    idle_cnt;

  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic                 accept;
  logic                 burst_end;
  logic                 idle_expire;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [DATA_BITS-1:0] cur_data;
  logic [STRB_BITS-1:0] cur_strb;

  assign grant_valid = (state == ST_LOCKED);

  // Walk downward so the closest candidate after last_grant is written last and wins.
  always_comb begin
    int cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[IDX_W'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_LOCKED) req_ready[grant_idx] = req_valid[grant_idx];
  end

  assign accept      = (state == ST_LOCKED) && req_valid[grant_idx];
  assign burst_end   = req_last[grant_idx] || (beat_cnt == BEAT_W'(MAX_BURST - 1));
  assign idle_expire = (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
  assign cur_addr    = req_addr[int'(grant_idx)*ADDR_BITS +: ADDR_BITS];
  assign cur_data    = req_data[int'(grant_idx)*DATA_BITS +: DATA_BITS];
  assign cur_strb    = req_strb[int'(grant_idx)*STRB_BITS +: STRB_BITS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      grant_idx  <= '0;
      beat_cnt   <= '0;
      idle_cnt   <= '0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
      fb_wr_en   <= '0;
    end else begin
      fb_wr_en <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_found) begin
            grant_idx  <= sel_idx;
            last_grant <= sel_idx;
            beat_cnt   <= '0;
            idle_cnt   <= '0;
            state      <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (accept) begin
            fb_wr_addr <= cur_addr;
            fb_wr_data <= cur_data;
            fb_wr_en   <= cur_strb;
            idle_cnt   <= '0;
            beat_cnt   <= beat_cnt + BEAT_W'(1);
            if (burst_end) state <= ST_IDLE;
          end else if (idle_expire) begin
            // Holder went quiet too long: drop the lock without issuing a write.
            state <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus random bursts,
// compared cycle by cycle against a transaction-level arbitration model.

module tb_fb_write_arbiter;

  localparam int NUM_REQ      = 2;
  localparam int ADDR_BITS    = 17;
  localparam int DATA_BITS    = 32;
  localparam int MAX_BURST    = 16;
  localparam int IDLE_TIMEOUT = 8;
  localparam int IDX_W        = 1;
  localparam int STRB_BITS    = DATA_BITS / 8;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
    logic [STRB_BITS-1:0] strb;
    logic                 last;
  } beat_t;

  typedef struct packed {
    logic [NUM_REQ-1:0]   rdy;
    logic                 gv;
    logic [IDX_W-1:0]     gidx;
    logic [STRB_BITS-1:0] en;
    logic [ADDR_BITS-1:0] addr;
    logic [DATA_BITS-1:0] data;
  } exp_t;

  logic                           clk;
  logic                           reset_n;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr;
  logic [NUM_REQ*DATA_BITS-1:0]   req_data;
  logic [NUM_REQ*STRB_BITS-1:0]   req_strb;
  logic [ADDR_BITS-1:0]           fb_wr_addr;
  logic [DATA_BITS-1:0]           fb_wr_data;
  logic [STRB_BITS-1:0]           fb_wr_en;
  logic                           grant_valid;
  logic [IDX_W-1:0]               grant_idx;

  fb_write_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .MAX_BURST(MAX_BURST), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data), .fb_wr_en(fb_wr_en),
    .grant_valid(grant_valid), .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int                   errors = 0;
  int                   checks = 0;
  beat_t                q [NUM_REQ][$];
  exp_t                 exp_q [$];
  logic [NUM_REQ-1:0]   obs_rdy;
  int                   mdl_last;
  logic [ADDR_BITS-1:0] mdl_addr;
  logic [DATA_BITS-1:0] mdl_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]                          = 1'b1;
        req_last[i]                           = q[i][0].last;
        req_addr[i*ADDR_BITS +: ADDR_BITS]    = q[i][0].addr;
        req_data[i*DATA_BITS +: DATA_BITS]    = q[i][0].data;
        req_strb[i*STRB_BITS +: STRB_BITS]    = q[i][0].strb;
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // One clock: observe handshake at the falling edge, retire accepted beats after the rise.
  task automatic cycle();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    obs_rdy = req_ready;
    acc     = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++) if (acc[i]) void'(q[i].pop_front());
    drive();
  endtask

  task automatic add_burst(input int r, input int len, input logic [ADDR_BITS-1:0] abase,
                           input logic [DATA_BITS-1:0] dbase, input logic [STRB_BITS-1:0] strb,
                           input logic with_last);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.addr = abase + ADDR_BITS'(4 * j);
      b.data = dbase + DATA_BITS'(j);
      b.strb = strb;
      b.last = with_last && (j == len - 1);
      q[r].push_back(b);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_REQ; i++) q[i].delete();
    mdl_last = NUM_REQ - 1;
    mdl_addr = '0;
    mdl_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Transaction model: round-robin over non-empty queues, bursts end on last,
  // MAX_BURST, or the holder running dry (then the idle timeout expires).
  task automatic build_expected();
    beat_t m [NUM_REQ][$];
    exp_t  e;
    beat_t b;
    int    w, n, last;
    logic  done, any;
    logic [ADDR_BITS-1:0] a;
    logic [DATA_BITS-1:0] d;
    for (int i = 0; i < NUM_REQ; i++) m[i] = q[i];
    last = mdl_last; a = mdl_addr; d = mdl_data;
    exp_q.delete();
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) if (m[i].size() > 0) any = 1'b1;
    while (any) begin
      w = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (w < 0 && m[(last + k) % NUM_REQ].size() > 0) w = (last + k) % NUM_REQ;
      last = w;
      e.rdy = '0; e.gv = 1'b1; e.gidx = IDX_W'(w); e.en = '0; e.addr = a; e.data = d;
      exp_q.push_back(e);
      n = 0; done = 1'b0;
      while (!done) begin
        b = m[w].pop_front();
        n++;
        a = b.addr; d = b.data;
        e.rdy = NUM_REQ'(1 << w);
        e.gv  = !(b.last || n == MAX_BURST);
        e.en  = b.strb; e.addr = a; e.data = d;
        exp_q.push_back(e);
        done = !e.gv || m[w].size() == 0;
      end
      if (e.gv) begin
        e.rdy = '0; e.en = '0;
        repeat (IDLE_TIMEOUT - 1) exp_q.push_back(e);
        e.gv = 1'b0;
        exp_q.push_back(e);
      end
      any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (m[i].size() > 0) any = 1'b1;
    end
    e.rdy = '0; e.gv = 1'b0; e.gidx = IDX_W'(last); e.en = '0; e.addr = a; e.data = d;
    exp_q.push_back(e);
    mdl_last = last; mdl_addr = a; mdl_data = d;
  endtask

  task automatic run(input string name);
    build_expected();
    drive();
    foreach (exp_q[j]) begin
      cycle();
      chk($sformatf("%s[%0d].ready", name, j), 64'(obs_rdy), 64'(exp_q[j].rdy));
      chk($sformatf("%s[%0d].gvalid", name, j), 64'(grant_valid), 64'(exp_q[j].gv));
      if (exp_q[j].gv)
        chk($sformatf("%s[%0d].gidx", name, j), 64'(grant_idx), 64'(exp_q[j].gidx));
      chk($sformatf("%s[%0d].wr_en", name, j), 64'(fb_wr_en), 64'(exp_q[j].en));
      chk($sformatf("%s[%0d].addr", name, j), 64'(fb_wr_addr), 64'(exp_q[j].addr));
      chk($sformatf("%s[%0d].data", name, j), 64'(fb_wr_data), 64'(exp_q[j].data));
    end
    for (int i = 0; i < NUM_REQ; i++)
      chk($sformatf("%s.drain%0d", name, i), 64'(q[i].size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".gvalid"}, 64'(grant_valid), 64'd0);
    chk({name, ".gidx"},   64'(grant_idx),   64'd0);
    chk({name, ".wr_en"},  64'(fb_wr_en),    64'd0);
    chk({name, ".addr"},   64'(fb_wr_addr),  64'd0);
    chk({name, ".data"},   64'(fb_wr_data),  64'd0);
    chk({name, ".ready"},  64'(req_ready),   64'd0);
  endtask

  initial begin
    beat_t b;
    reset_n   = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    req_strb  = '0;

    do_reset();
    chk_all_zero("reset");

    do_reset();
    add_burst(0, 3, 17'h10, 32'hA1, 4'hF, 1'b1);
    run("single");

    do_reset();
    add_burst(0, 2, 17'h100, 32'h1000, 4'hF, 1'b1);
    add_burst(0, 2, 17'h200, 32'h2000, 4'hF, 1'b1);
    add_burst(1, 2, 17'h300, 32'h3000, 4'hF, 1'b1);
    run("contend");

    do_reset();
    add_burst(0, 20, 17'h400, 32'h4000, 4'hF, 1'b0);
    add_burst(1, 3, 17'h800, 32'h8000, 4'hF, 1'b1);
    run("maxburst");

    do_reset();
    add_burst(0, 1, 17'h40, 32'h55, 4'hF, 1'b0);
    add_burst(1, 2, 17'h900, 32'h9000, 4'hF, 1'b1);
    run("timeout");

    // Zero-strobe beat must still count toward the 16-beat cutoff.
    do_reset();
    add_burst(0, 1, 17'h20, 32'hB1, 4'h3, 1'b0);
    add_burst(0, 1, 17'h24, 32'hB2, 4'h0, 1'b0);
    add_burst(0, 1, 17'h28, 32'hB3, 4'hC, 1'b0);
    add_burst(0, 17, 17'h2C, 32'hC0, 4'hF, 1'b1);
    run("strobe");

    do_reset();
    add_burst(0, 4, 17'h500, 32'h5000, 4'hF, 1'b1);
    drive();
    repeat (3) cycle();
    chk("midrst.pre_en", 64'(fb_wr_en), 64'hF);
    chk("midrst.pre_addr", 64'(fb_wr_addr), 64'h504);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    clear_model();
    add_burst(0, 2, 17'h600, 32'h6000, 4'hF, 1'b1);
    add_burst(1, 2, 17'h700, 32'h7000, 4'hF, 1'b1);
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run("post_rst");

    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
        int nb;
        nb = int'($urandom_range(1, 3));
        for (int k = 0; k < nb; k++) begin
          int len;
          len = int'($urandom_range(1, 22));
          for (int j = 0; j < len; j++) begin
            b.addr = ADDR_BITS'($urandom);
            b.data = $urandom;
            b.strb = STRB_BITS'($urandom_range(0, 15));
            b.last = (j == len - 1);
            q[i].push_back(b);
          end
        end
      end
      run($sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
